div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer.sv | 149 ++++++++++++++
 tb/tb_div_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divider: one restoring shift-subtract step per cycle,
// a sign-fix cycle, and single-cycle fast paths for divide-by-zero and overflow.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      tag_q, tag_d;
  logic [4:0]      rd_q, rd_d;
  logic            is_rem_q, is_rem_d;
  logic            neg1_q, neg1_d;
  logic            neg2_q, neg2_d;

  logic            signed_op, a_neg, b_neg, div0, ovf, fast, accept;
  logic [XLEN-1:0] a_abs, b_abs, fast_res, q_fix, r_fix;
  logic [XLEN+1:0] trial;

  always_comb begin
    signed_op = ~funct3[0];
    a_neg     = signed_op & rs1[XLEN-1];
    b_neg     = signed_op & rs2[XLEN-1];
    a_abs     = a_neg ? -rs1 : rs1;
    b_abs     = b_neg ? -rs2 : rs2;
    div0      = (rs2 == '0);
    ovf       = signed_op && (rs1 == MIN_NEG) && (rs2 == '1);
    fast      = div0 | ovf;
    accept    = start & funct3[2] & ~flush & ((state_q == IDLE) | (state_q == DONE));
    if (div0) fast_res = funct3[1] ? rs1 : '1;
    else      fast_res = funct3[1] ? '0  : MIN_NEG;
    // Shift next dividend bit into the partial remainder and trial-subtract.
    trial = {rem_q, quo_q[XLEN-1]} - {2'b00, dvs_q};
    q_fix = (neg1_q ^ neg2_q) ? -quo_q : quo_q;
    r_fix = neg1_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    res_d    = res_q;
    tag_d    = tag_q;
    rd_d     = rd_q;
    is_rem_d = is_rem_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          cnt_d    = '0;
          rem_d    = '0;
          quo_d    = a_abs;
          dvs_d    = b_abs;
          tag_d    = rd_in;
          is_rem_d = funct3[1];
          neg1_d   = a_neg;
          neg2_d   = b_neg;
          if (fast) begin
            state_d = DONE;
            res_d   = fast_res;
            rd_d    = rd_in;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = trial[XLEN+1] ? {rem_q[XLEN-1:0], quo_q[XLEN-1]} : trial[XLEN:0];
          quo_d = {quo_q[XLEN-2:0], ~trial[XLEN+1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) state_d = SIGN;
        end
      end
      SIGN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          res_d   = is_rem_q ? r_fix : q_fix;
          rd_d    = tag_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      tag_q    <= '0;
      rd_q     <= '0;
      is_rem_q <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      res_q    <= res_d;
      tag_q    <= tag_d;
      rd_q     <= rd_d;
      is_rem_q <= is_rem_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
    end
  end

  assign busy   = (state_q == RUN) || (state_q == SIGN);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed RV32M cases, flush/reset/back-to-back
// timing, and randomized operations against an arithmetic reference model.
module tb_div_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, result;
  logic [4:0]  rd_in, rd_out;
  logic        busy, done;
  int total = 0;
  int bad   = 0;

  div_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .rd_in(rd_in), .flush(flush), .busy(busy), .done(done), .result(result),
    .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : 32'h8000_0000;
    if (!f3[0]) return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
    return f3[1] ? a % b : a / b;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  // Issues one op (at the next negedge unless now=1) and waits for its done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit now,
                        output logic [31:0] r, output logic [4:0] t, output int lat, output int busy_n);
    if (!now) @(negedge clk);
    funct3 = f3; rs1 = a; rs2 = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    lat = -1; busy_n = 0; r = 'x; t = 'x;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        lat = c; r = result; t = rd_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; flush = 1'b1; funct3 = 3'b101; rs1 = 100; rs2 = 7; rd_in = 5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    total++; if (rd_out !== 5'h0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", rd_out); end
    rst = 1'b0; start = 1'b0; flush = 1'b0;
  endtask

  task automatic test_divu_basic();
    logic [31:0] r; logic [4:0] t; int lat, bn;
    run_op(3'b101, 32'd100, 32'd7, 5'd5, 0, r, t, lat, bn);
    total++; if (lat !== 34) begin bad++; $display("FAIL divu_latency got=%0d exp=34", lat); end
    total++; if (bn !== 33) begin bad++; $display("FAIL divu_busy_cycles got=%0d exp=33", bn); end
    total++; if (r !== 32'd14) begin bad++; $display("FAIL divu_result got=%h exp=%h", r, 32'd14); end
    total++; if (t !== 5'd5) begin bad++; $display("FAIL divu_rd got=%0d exp=5", t); end
    run_op(3'b111, 32'd100, 32'd7, 5'd6, 0, r, t, lat, bn);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL remu_result got=%h exp=2", r); end
    @(negedge clk);
    total++; if (result !== 32'd2 || done !== 1'b0) begin bad++; $display("FAIL result_hold got=%h/%b exp=2/0", result, done); end
  endtask

  task automatic test_signed();
    logic [2:0]  f3 [3] = '{3'b100, 3'b110, 3'b110};
    logic [31:0] a  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
    logic [31:0] b  [3] = '{32'd2, 32'd2, 32'hFFFF_FFFE};
    logic [31:0] e  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] r; logic [4:0] t; int lat, bn;
    for (int i = 0; i < 3; i++) begin
      run_op(f3[i], a[i], b[i], 5'(i + 10), 0, r, t, lat, bn);
      total++; if (r !== e[i] || lat !== 34) begin bad++; $display("FAIL signed_%0d got=%h lat=%0d exp=%h lat=34", i, r, lat, e[i]); end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  f3 [6] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] a  [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
    logic [31:0] b  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] e  [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    logic [31:0] r; logic [4:0] t; int lat, bn;
    for (int i = 0; i < 6; i++) begin
      run_op(f3[i], a[i], b[i], 5'(i + 20), 0, r, t, lat, bn);
      total++; if (r !== e[i] || lat !== 1 || bn !== 0 || t !== 5'(i + 20))
        begin bad++; $display("FAIL fast_%0d got=%h lat=%0d busy=%0d rd=%0d exp=%h lat=1 busy=0 rd=%0d", i, r, lat, bn, t, e[i], i + 20); end
    end
  endtask

  task automatic test_ignored();
    logic [31:0] prev;
    prev = result;
    @(negedge clk);
    funct3 = 3'b001; rs1 = 9; rs2 = 3; rd_in = 1; start = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL non_div_start got=%b%b exp=00", busy, done); end
    funct3 = 3'b101; flush = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || result !== prev) begin bad++; $display("FAIL flush_start got=%b%b %h exp=00 %h", busy, done, result, prev); end
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic test_flush();
    logic [31:0] prev, r; logic [4:0] prd, t; int lat, bn; bit seen;
    prev = result; prd = rd_out; seen = 0;
    @(negedge clk);
    funct3 = 3'b101; rs1 = 1000; rs2 = 3; rd_in = 9; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || seen) begin bad++; $display("FAIL flush_idle got=busy%b done%b early%b exp=000", busy, done, seen); end
    total++; if (result !== prev || rd_out !== prd) begin bad++; $display("FAIL flush_hold got=%h/%0d exp=%h/%0d", result, rd_out, prev, prd); end
    run_op(3'b100, 32'hFFFF_FC18, 32'd7, 5'd12, 1, r, t, lat, bn);
    total++; if (r !== ref_div(3'b100, 32'hFFFF_FC18, 32'd7) || lat !== 34 || t !== 5'd12)
      begin bad++; $display("FAIL flush_restart got=%h lat=%0d rd=%0d exp=%h lat=34 rd=12", r, lat, t, ref_div(3'b100, 32'hFFFF_FC18, 32'd7)); end
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    c1 = -1; c2 = -1;
    @(negedge clk);
    funct3 = 3'b101; rs1 = 200; rs2 = 9; rd_in = 3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    funct3 = 3'b111; rd_in = 4;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin c1 = c; break; end
      @(negedge clk);
    end
    total++; if (c1 !== 34 || result !== 32'd22 || rd_out !== 5'd3 || busy !== 1'b0)
      begin bad++; $display("FAIL b2b_first got=cyc%0d %h rd%0d busy%b exp=cyc34 16 rd3 busy0", c1, result, rd_out, busy); end
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_accept got=busy%b done%b exp=busy1 done0", busy, done); end
    for (int c = 35; c <= 80; c++) begin
      if (done) begin c2 = c; break; end
      @(negedge clk);
    end
    total++; if (c2 !== 68 || result !== 32'd2 || rd_out !== 5'd4)
      begin bad++; $display("FAIL b2b_second got=cyc%0d %h rd%0d exp=cyc68 2 rd4", c2, result, rd_out); end
  endtask

  task automatic test_rst_mid();
    logic [31:0] r; logic [4:0] t; int lat, bn; bit seen;
    seen = 0;
    @(negedge clk);
    funct3 = 3'b101; rs1 = 77; rs2 = 5; rd_in = 7; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1;
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || rd_out !== 5'h0 || seen)
      begin bad++; $display("FAIL rst_mid got=busy%b done%b %h rd%0d early%b exp=0 0 0 0 0", busy, done, result, rd_out, seen); end
    rst = 1'b0;
    run_op(3'b111, 32'd77, 32'd5, 5'd8, 1, r, t, lat, bn);
    total++; if (r !== 32'd2 || lat !== 34 || t !== 5'd8) begin bad++; $display("FAIL rst_restart got=%h lat=%0d rd=%0d exp=2 lat=34 rd=8", r, lat, t); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r; logic [2:0] f3; logic [4:0] rd, t; int lat, bn;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      rd = 5'($urandom);
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: a = 32'h0;
        2: a = 32'($urandom_range(0, 100));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: b = $urandom;
      endcase
      run_op(f3, a, b, rd, 0, r, t, lat, bn);
      total++;
      if (r !== ref_div(f3, a, b) || t !== rd || lat !== ref_lat(f3, a, b))
        begin bad++; $display("FAIL rand_%0d f3=%b a=%h b=%h got=%h rd%0d lat%0d exp=%h rd%0d lat%0d", i, f3, a, b, r, t, lat, ref_div(f3, a, b), rd, ref_lat(f3, a, b)); end
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_fast_path();
    test_ignored();
    test_flush();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
